// File: rtl/sc_pkg.sv
// sc_pkg -- shared definitions for the sc_clk_ctrl clock/reset controller.
// Holds the controller state encoding, the four instruction-period phase
// constants, the default reset-hold length and the phase-to-clock decode.
package sc_pkg;

  // Controller states. HOLD is the post-reset hold-off, RUN free-runs,
  // HALT freezes the period at phase 0, STEP runs exactly one period.
  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_STEP = 2'd3
  } sc_state_t;

  // Phases of one instruction period.
  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  // Default number of cpu_clock cycles the CPU reset is held after resetn.
  localparam int SC_RESET_HOLD_DEF = 8;

  // CPU clock is high in the second half of the period (phases 2 and 3).
  function automatic logic phase_clock(input logic [1:0] ph);
    return (ph == PH_2) || (ph == PH_3);
  endfunction

  // Memory clock runs at twice the CPU rate: high in phases 1 and 3.
  function automatic logic phase_mem_clk(input logic [1:0] ph);
    return (ph == PH_1) || (ph == PH_3);
  endfunction

endpackage : sc_pkg

// File: rtl/sc_clk_ctrl_if.sv
// sc_clk_ctrl_if -- request/status bundle between the clock controller and
// the debugger/CPU side.
//
// Handshake: run_req, halt_req and step_req are single-cycle pulses sampled
// on the rising cpu_clock edge; there is no ready/acknowledge -- a request
// the controller cannot act on in its current state is dropped (except
// halt_req in RUN, which is remembered until the end of the current period).
// step_done and bp_hit are single-cycle status pulses; halted, phase,
// clock, mem_clk, cpu_resetn and instr_count are level outputs.
interface sc_clk_ctrl_if;

  // Requests and breakpoint inputs (driven by the master side)
  logic        run_req;
  logic        halt_req;
  logic        step_req;
  logic [31:0] pc;
  logic        bp_en;
  logic [31:0] bp_addr;

  // Generated clocks, reset and status (driven by the controller)
  logic        clock;
  logic        mem_clk;
  logic        cpu_resetn;
  logic [1:0]  phase;
  logic        halted;
  logic        step_done;
  logic        bp_hit;
  logic [31:0] instr_count;

  // Debugger / CPU side
  modport master (
    output run_req, halt_req, step_req, pc, bp_en, bp_addr,
    input  clock, mem_clk, cpu_resetn, phase, halted, step_done, bp_hit,
           instr_count
  );

  // Clock controller side
  modport slave (
    input  run_req, halt_req, step_req, pc, bp_en, bp_addr,
    output clock, mem_clk, cpu_resetn, phase, halted, step_done, bp_hit,
           instr_count
  );

endinterface : sc_clk_ctrl_if

// File: rtl/sc_bp_match.sv
// sc_bp_match -- breakpoint address compare with a one-period exemption.
// After the controller leaves HALT the first period end must not re-trigger
// the breakpoint that stopped it, so an exemption flag is armed on leaving
// HALT and disarmed at the next period end.
module sc_bp_match (
  input  logic        cpu_clock,
  input  logic        resetn,
  input  logic        i_bp_en,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_bp_addr,
  input  logic        i_leave_halt,
  input  logic        i_wrap,
  output logic        o_match,
  output logic        o_exempt
);

  logic r_exempt;

  // Arm the exemption when leaving HALT; clear it at the following wrap.
  always_ff @(posedge cpu_clock or negedge resetn) begin
    if (!resetn) begin
      r_exempt <= 1'b0;
    end else if (i_leave_halt) begin
      r_exempt <= 1'b1;
    end else if (i_wrap) begin
      r_exempt <= 1'b0;
    end
  end

  assign o_match  = i_bp_en && (i_pc == i_bp_addr) && !r_exempt;
  assign o_exempt = r_exempt;

endmodule : sc_bp_match

// File: rtl/sc_clk_ctrl.sv
// sc_clk_ctrl -- four-phase CPU/memory clock generator with reset hold-off,
// run/halt/single-step control and an instruction-period counter.
//
// Optional feature: define SC_CLK_CTRL_BP_EN to add a PC breakpoint that
// halts the CPU at the end of the period whose pc equals bp_addr. Without
// it the breakpoint inputs are ignored and bp_hit stays 0.
//
// Clocks are registered from the next-phase value so that clock and mem_clk
// always line up with the phase output: phase 0,1,2,3 gives clock 0,0,1,1
// and mem_clk 0,1,0,1.
module sc_clk_ctrl
  import sc_pkg::*;
#(
  parameter int RESET_HOLD = SC_RESET_HOLD_DEF,
  parameter bit START_RUN  = 1'b1
) (
  input  logic         cpu_clock,
  input  logic         resetn,
  sc_clk_ctrl_if.slave bus,
  output sc_state_t    o_dbg_state
);

  localparam logic [31:0] HOLD_CYCLES = 32'(RESET_HOLD);

  // State and datapath registers
  sc_state_t   r_state;
  logic [1:0]  r_phase;
  logic        r_clock;
  logic        r_mem_clk;
  logic        r_cpu_resetn;
  logic        r_halted;
  logic        r_step_done;
  logic        r_bp_hit;
  logic [31:0] r_instr_count;
  logic        r_halt_pend;
  logic [31:0] r_hold_cnt;

  // Next-state values
  sc_state_t   w_state_nxt;
  logic [1:0]  w_phase_nxt;
  logic [31:0] w_count_nxt;
  logic        w_halt_pend_nxt;
  logic [31:0] w_hold_cnt_nxt;
  logic        w_step_done_nxt;
  logic        w_bp_hit_nxt;

  // Decoded conditions
  logic        w_active;
  logic        w_wrap;
  logic        w_leave_halt;
  logic        w_bp_match;

  // The period only advances in RUN and STEP; a wrap is the 3->0 edge.
  assign w_active     = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_wrap       = w_active && (r_phase == PH_3);
  assign w_leave_halt = (r_state == ST_HALT) && (w_state_nxt != ST_HALT);
  assign w_phase_nxt  = w_active ? (r_phase + 2'd1) : PH_0;
  assign w_count_nxt  = w_wrap ? (r_instr_count + 32'd1) : r_instr_count;

`ifdef SC_CLK_CTRL_BP_EN
  logic w_bp_exempt;

  sc_bp_match u_bp_match (
    .cpu_clock    (cpu_clock),
    .resetn       (resetn),
    .i_bp_en      (bus.bp_en),
    .i_pc         (bus.pc),
    .i_bp_addr    (bus.bp_addr),
    .i_leave_halt (w_leave_halt),
    .i_wrap       (w_wrap),
    .o_match      (w_bp_match),
    .o_exempt     (w_bp_exempt)
  );
`else
  // Breakpoint hardware absent: inputs are read only into a sink.
  logic w_bp_unused;
  assign w_bp_unused = bus.bp_en ^ (^bus.pc) ^ (^bus.bp_addr) ^ w_leave_halt;
  assign w_bp_match  = 1'b0;
`endif

  // State register.
  always_ff @(posedge cpu_clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_HOLD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, pending-halt, hold counter and status pulse decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_halt_pend_nxt = r_halt_pend;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_step_done_nxt = 1'b0;
    w_bp_hit_nxt    = 1'b0;
    case (r_state)
      ST_HOLD: begin
        w_hold_cnt_nxt = r_hold_cnt + 32'd1;
        if ((r_hold_cnt + 32'd1) >= HOLD_CYCLES) begin
          w_state_nxt = START_RUN ? ST_RUN : ST_HALT;
        end
      end
      ST_RUN: begin
        // A halt request is remembered and only acted on at the wrap so
        // the CPU always sees whole instruction periods.
        if (bus.halt_req) begin
          w_halt_pend_nxt = 1'b1;
        end
        if (w_wrap) begin
          w_bp_hit_nxt = w_bp_match;
          if (r_halt_pend || bus.halt_req || w_bp_match) begin
            w_state_nxt     = ST_HALT;
            w_halt_pend_nxt = 1'b0;
          end
        end
      end
      ST_HALT: begin
        w_halt_pend_nxt = 1'b0;
        // halt_req outranks run/step but has nothing to do while halted.
        if (!bus.halt_req) begin
          if (bus.run_req) begin
            w_state_nxt = ST_RUN;
          end else if (bus.step_req) begin
            w_state_nxt = ST_STEP;
          end
        end
      end
      ST_STEP: begin
        if (w_wrap) begin
          w_state_nxt     = ST_HALT;
          w_step_done_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_HOLD;
      end
    endcase
  end

  // Phase, clocks, CPU reset, status and counters.
  always_ff @(posedge cpu_clock or negedge resetn) begin
    if (!resetn) begin
      r_phase       <= PH_0;
      r_clock       <= 1'b0;
      r_mem_clk     <= 1'b0;
      r_cpu_resetn  <= 1'b0;
      r_halted      <= 1'b0;
      r_step_done   <= 1'b0;
      r_bp_hit      <= 1'b0;
      r_instr_count <= 32'd0;
      r_halt_pend   <= 1'b0;
      r_hold_cnt    <= 32'd0;
    end else begin
      r_phase       <= w_phase_nxt;
      r_clock       <= phase_clock(w_phase_nxt);
      r_mem_clk     <= phase_mem_clk(w_phase_nxt);
      r_cpu_resetn  <= (w_state_nxt != ST_HOLD);
      r_halted      <= (w_state_nxt == ST_HALT);
      r_step_done   <= w_step_done_nxt;
      r_bp_hit      <= w_bp_hit_nxt;
      r_instr_count <= w_count_nxt;
      r_halt_pend   <= w_halt_pend_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
    end
  end

  assign bus.clock       = r_clock;
  assign bus.mem_clk     = r_mem_clk;
  assign bus.cpu_resetn  = r_cpu_resetn;
  assign bus.phase       = r_phase;
  assign bus.halted      = r_halted;
  assign bus.step_done   = r_step_done;
  assign bus.bp_hit      = r_bp_hit;
  assign bus.instr_count = r_instr_count;
  assign o_dbg_state     = r_state;

endmodule : sc_clk_ctrl

// File: tb/tb_sc_clk_ctrl.sv
// tb_sc_clk_ctrl -- self-checking bench for sc_clk_ctrl (RESET_HOLD=8,
// START_RUN=1). Breakpoint checks depend on SC_CLK_CTRL_BP_EN.
module tb_sc_clk_ctrl;
  import sc_pkg::*;

  localparam int RESET_HOLD = 8;
  localparam int W          = 40;
  localparam int N_VEC      = 24;

  // ---------------- clock / reset ----------------
  logic      cpu_clock = 1'b0;
  logic      resetn    = 1'b0;
  sc_state_t dbg_state;

  sc_clk_ctrl_if bus ();

  sc_clk_ctrl #(
    .RESET_HOLD (RESET_HOLD),
    .START_RUN  (1'b1)
  ) dut (
    .cpu_clock   (cpu_clock),
    .resetn      (resetn),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 cpu_clock = ~cpu_clock;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int           run;
    int           halt;
    int           step;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[N_VEC];

  // Expected observation: clocks follow the phase (clock high in 2,3;
  // mem_clk high in 1,3).
  function automatic logic [W-1:0] ev(input int rstn, input int hlt,
                                      input int sd, input int bh,
                                      input int ph, input int cnt);
    logic c;
    logic m;
    c = (ph == 2) || (ph == 3);
    m = (ph == 1) || (ph == 3);
    return {1'(rstn), 1'(hlt), 1'(sd), 1'(bh), c, m, 2'(ph), 32'(cnt)};
  endfunction

  function automatic logic [W-1:0] observe();
    return {bus.cpu_resetn, bus.halted, bus.step_done, bus.bp_hit,
            bus.clock, bus.mem_clk, bus.phase, bus.instr_count};
  endfunction

  function automatic string fmt(input logic [W-1:0] v);
    return $sformatf("rstn=%b halted=%b step_done=%b bp_hit=%b clock=%b mem_clk=%b phase=%0d count=%h",
                     v[39], v[38], v[37], v[36], v[35], v[34], v[33:32], v[31:0]);
  endfunction

  task automatic check(input string name);
    logic [W-1:0] act;
    logic [W-1:0] exp;
    act = observe();
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: no expected entry queued, actual %s", name, fmt(act));
      return;
    end
    exp = exp_q.pop_front();
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %s / required %s", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_state(input string name, input sc_state_t exp_st);
    n_checks++;
    if (dbg_state !== exp_st) begin
      n_errors++;
      $display("FAIL %s: actual state %s / required %s", name, dbg_state.name(), exp_st.name());
    end
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: present request pulses, queue the expectation, clock, compare.
  task automatic cyc(input int run, input int halt, input int step,
                     input logic [W-1:0] exp, input string name);
    bus.run_req  = 1'(run);
    bus.halt_req = 1'(halt);
    bus.step_req = 1'(step);
    exp_q.push_back(exp);
    @(posedge cpu_clock);
    #1;
    bus.run_req  = 1'b0;
    bus.halt_req = 1'b0;
    bus.step_req = 1'b0;
    check(name);
  endtask

  // Assert reset mid-cycle and require every output at reset value at once.
  task automatic async_reset(input string name);
    #2;
    resetn = 1'b0;
    #1;
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
    check(name);
    check_state(name, ST_HOLD);
  endtask

  // Release reset right after an edge and walk through the hold-off.
  task automatic release_and_hold();
    @(posedge cpu_clock);
    #1;
    resetn = 1'b1;
    for (int n = 1; n <= RESET_HOLD; n++) begin
      if (n < RESET_HOLD) cyc(0, 0, 0, ev(0, 0, 0, 0, 0, 0), "hold_seq");
      else                cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 0), "hold_release");
    end
  endtask

  // Safety net against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

  // ---------------- test ----------------
  initial begin
    bus.run_req  = 1'b0;
    bus.halt_req = 1'b0;
    bus.step_req = 1'b0;
    bus.pc       = 32'd0;
    bus.bp_en    = 1'b0;
    bus.bp_addr  = 32'd0;

    // Table: cycles after reset release. Requests in HOLD/RUN other than
    // halt must be ignored.
    for (int i = 0; i < N_VEC; i++) begin
      int n;
      n = i + 1;
      vecs[i].run  = 0;
      vecs[i].halt = 0;
      vecs[i].step = 0;
      if (n < RESET_HOLD) vecs[i].exp = ev(0, 0, 0, 0, 0, 0);
      else                vecs[i].exp = ev(1, 0, 0, 0, (n - RESET_HOLD) % 4, (n - RESET_HOLD) / 4);
    end
    vecs[2].run  = 1;
    vecs[5].step = 1;
    vecs[13].step = 1;
    vecs[16].run = 1;

    #2;
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
    check("reset_state");
    check_state("reset_state", ST_HOLD);

    repeat (2) @(posedge cpu_clock);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < N_VEC; i++) begin
      cyc(vecs[i].run, vecs[i].halt, vecs[i].step, vecs[i].exp, "reset_run_table");
    end
    // RUN, phase 0, count 4

    // Halt requested in phase 1: finish the period, then HALT.
    cyc(0, 0, 0, ev(1, 0, 0, 0, 1, 4), "run_ph1");
    cyc(0, 1, 0, ev(1, 0, 0, 0, 2, 4), "halt_req_continue_ph2");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 3, 4), "halt_req_continue_ph3");
    cyc(0, 0, 0, ev(1, 1, 0, 0, 0, 5), "halt_at_wrap");
    check_state("halt_at_wrap", ST_HALT);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, ev(1, 1, 0, 0, 0, 5), "halt_frozen");

    // Single step; repeated step_req and halt_req during STEP do nothing.
    cyc(0, 0, 1, ev(1, 0, 0, 0, 0, 5), "step_enter");
    cyc(0, 0, 1, ev(1, 0, 0, 0, 1, 5), "step_ph1_req_ignored");
    cyc(0, 1, 0, ev(1, 0, 0, 0, 2, 5), "step_ph2_halt_noop");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 3, 5), "step_ph3");
    cyc(0, 0, 0, ev(1, 1, 1, 0, 0, 6), "step_done");
    cyc(0, 0, 0, ev(1, 1, 0, 0, 0, 6), "step_done_one_cycle");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, ev(1, 1, 0, 0, 0, 6), "halt_after_step");

    // halt+run together while halted: stay halted.
    cyc(1, 1, 0, ev(1, 1, 0, 0, 0, 6), "halt_beats_run_in_halt");
    cyc(0, 0, 0, ev(1, 1, 0, 0, 0, 6), "still_halted");
    cyc(1, 0, 0, ev(1, 0, 0, 0, 0, 6), "run_from_halt");
    // halt+run together while running: halt at next wrap.
    cyc(1, 1, 0, ev(1, 0, 0, 0, 1, 6), "run_halt_in_run_ph1");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 2, 6), "run_halt_in_run_ph2");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 3, 6), "run_halt_in_run_ph3");
    cyc(0, 0, 0, ev(1, 1, 0, 0, 0, 7), "run_halt_in_run_wrap");

    // run+step together while halted: run wins and keeps running.
    cyc(1, 0, 1, ev(1, 0, 0, 0, 0, 7), "run_beats_step");
    check_state("run_beats_step", ST_RUN);
    cyc(0, 0, 0, ev(1, 0, 0, 0, 1, 7), "run_beats_step_ph1");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 2, 7), "run_beats_step_ph2");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 3, 7), "run_beats_step_ph3");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 8), "run_continues_past_wrap");

    // Counter preset to all-ones in phase 0, then wraps to 0.
    force dut.r_instr_count = 32'hFFFF_FFFF;
    cyc(0, 0, 0, ev(1, 0, 0, 0, 1, 32'hFFFF_FFFF), "count_preset");
    release dut.r_instr_count;
    cyc(0, 0, 0, ev(1, 0, 0, 0, 2, 32'hFFFF_FFFF), "count_preset_held_ph2");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 3, 32'hFFFF_FFFF), "count_preset_held_ph3");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 0), "count_wrap_to_zero");

    // Reset in phase 2 of RUN.
    cyc(0, 0, 0, ev(1, 0, 0, 0, 1, 0), "pre_reset_ph1");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 2, 0), "pre_reset_ph2");
    async_reset("async_reset_ph2");
    cyc(0, 0, 0, ev(0, 0, 0, 0, 0, 0), "reset_held");

    // Reset in the middle of a STEP: no step_done afterwards.
    release_and_hold();
    cyc(0, 1, 0, ev(1, 0, 0, 0, 1, 0), "abort_setup_ph1");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 2, 0), "abort_setup_ph2");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 3, 0), "abort_setup_ph3");
    cyc(0, 0, 0, ev(1, 1, 0, 0, 0, 1), "abort_setup_halt");
    cyc(0, 0, 1, ev(1, 0, 0, 0, 0, 1), "abort_step_ph0");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 1, 1), "abort_step_ph1");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 2, 1), "abort_step_ph2");
    async_reset("async_reset_mid_step");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, ev(0, 0, 0, 0, 0, 0), "no_step_done_after_abort");

    release_and_hold();
    bus.bp_en   = 1'b1;
    bus.bp_addr = 32'h0000_000C;
`ifdef SC_CLK_CTRL_BP_EN
    // pc 0x0,0x4,0x8,0xC per period: break at the end of the 0xC period.
    for (int p = 0; p < 4; p++) begin
      bus.pc = 32'(p * 4);
      cyc(0, 0, 0, ev(1, 0, 0, 0, 1, p), "bp_ph1");
      cyc(0, 0, 0, ev(1, 0, 0, 0, 2, p), "bp_ph2");
      cyc(0, 0, 0, ev(1, 0, 0, 0, 3, p), "bp_ph3");
      if (p < 3) cyc(0, 0, 0, ev(1, 0, 0, 0, 0, p + 1), "bp_no_hit_wrap");
      else       cyc(0, 0, 0, ev(1, 1, 0, 1, 0, 4), "bp_hit_wrap");
    end
    cyc(0, 0, 0, ev(1, 1, 0, 0, 0, 4), "bp_hit_one_cycle");
    // Resume with pc still on the breakpoint: first wrap exempt.
    cyc(1, 0, 0, ev(1, 0, 0, 0, 0, 4), "bp_resume");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 1, 4), "bp_resume_ph1");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 2, 4), "bp_resume_ph2");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 3, 4), "bp_resume_ph3");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 5), "bp_exempt_wrap");
    // Exemption covers one wrap only.
    cyc(0, 0, 0, ev(1, 0, 0, 0, 1, 5), "bp_again_ph1");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 2, 5), "bp_again_ph2");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 3, 5), "bp_again_ph3");
    cyc(0, 0, 0, ev(1, 1, 0, 1, 0, 6), "bp_rehit_wrap");
`else
    // No breakpoint hardware: matching pc must not stop the CPU.
    bus.pc = 32'h0000_000C;
    cyc(0, 0, 0, ev(1, 0, 0, 0, 1, 0), "nobp_ph1");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 2, 0), "nobp_ph2");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 3, 0), "nobp_ph3");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 1), "nobp_wrap_keeps_running");
    cyc(0, 0, 0, ev(1, 0, 0, 0, 1, 1), "nobp_next_ph1");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sc_clk_ctrl
